sensor_debounce: RTL and testbench
==================================

// Module: sensor_debounce
// PURPOSE
//  Input conditioner directly upstream of the auto_con sensor logic.
//  Takes the four raw sensor inputs from board switches/buttons (ct, cl, ot, ol).
//  Synchronises and debounces each one, then drives clean levels plus 1-cycle
//  rise/fall pulses. sensor_out[0..3] map to ct, cl, ot, ol.
// PARAMETERS
//  N_CH             4          number of sensor channels
//  DEBOUNCE_CYCLES  1000000    consecutive cycles a change must persist
//                              (10 ms @ 100 MHz); legal range >= 1
//  CNT_W            $clog2(DEBOUNCE_CYCLES+1)  counter width, derived, do not override
// PORTS
//  clk         in   1     system clock; all state on rising edge
//  rst         in   1     asynchronous, active-high reset
//  sensor_raw  in   N_CH  raw, asynchronous sensor inputs
//  sensor_out  out  N_CH  debounced sensor levels (registered)
//  rise        out  N_CH  1-cycle pulse when sensor_out bit goes 0->1
//  fall        out  N_CH  1-cycle pulse when sensor_out bit goes 1->0
//  chg_flag    out  N_CH  [SENSOR_STICKY_EN only] sticky change flags
//  chg_clr     in   N_CH  [SENSOR_STICKY_EN only] per-bit clear of chg_flag
// BEHAVIOUR
//  - Reset (async, rst=1): s1, s2, sensor_out, rise, fall, all counters (and
//    chg_flag) = 0 immediately; state is held while rst=1.
//  - Sync: two flops per channel, sensor_raw -> s1 -> s2. No logic between them.
//  - Per-channel counter, evaluated at each rising edge:
//      if s2 == sensor_out:                cnt <= 0
//      else if cnt == DEBOUNCE_CYCLES-1:   sensor_out <= s2; cnt <= 0
//      else:                               cnt <= cnt + 1
//  - Latency: a raw change first sampled at edge k appears on sensor_out
//    after edge k+1+DEBOUNCE_CYCLES (DEBOUNCE_CYCLES+2 edges in total).
//  - Glitch rejection: s2 returning to sensor_out before the terminal count
//    clears cnt. The next change restarts from 0; there is no partial credit.
//  - rise/fall: registered on the same edge that updates sensor_out.
//    Each is high for exactly the first cycle of the new level and 0 otherwise.
//    rise and fall are never high together on one channel.
//  - Channels are fully independent. Simultaneous changes on several channels
//    yield simultaneous pulses.
//  - Raw input held at 1 through reset release: sensor_out rises after
//    DEBOUNCE_CYCLES+2 edges and rise pulses once. This is required behaviour.
//  - Reset mid-count: counter and pending change are discarded. After release,
//    debouncing restarts from sensor_out = 0.
//  - Counter never wraps: maximum value is DEBOUNCE_CYCLES-1.
//  - DEBOUNCE_CYCLES = 1: sensor_out follows s2 one edge later (3-flop delay).
// CONFIGURATION
//  SENSOR_STICKY_EN defined:
//    - Adds the chg_flag and chg_clr ports.
//    - chg_flag[i] <= 1 on any rise[i] or fall[i]. It holds until a cycle with
//      chg_clr[i]=1.
//    - Set wins over clear in the same cycle, so no event is lost.
//    - chg_flag resets to 0.
//  SENSOR_STICKY_EN undefined:
//    - Ports chg_flag and chg_clr are absent and no flag logic is built.
//    - All other behaviour is identical.
// TESTING (bench overrides DEBOUNCE_CYCLES=4; clk period 10 ns)
//  1 rst=1 with sensor_raw=4'hF, release -> outputs 0 during reset;
//    sensor_out=4'hF and rise=4'hF for 1 cycle, 6 edges after release.
//  2 sensor_raw[0] 0->1 held -> sensor_out[0]=1 after 6th edge;
//    rise[0] exactly 1 cycle; other bits unchanged.
//  3 sensor_raw[1] 3-cycle high glitch -> sensor_out[1] stays 0 and no pulse;
//    a later 4+ cycle high is accepted with full 6-edge latency.
//  4 sensor_raw 4'h0->4'hA simultaneous -> rise=4'hA on one cycle;
//    then 4'hA->4'h5 -> fall=4'hA and rise=4'h5 on the same cycle.
//  5 rst asserted 2 cycles into a pending change -> everything 0 at once;
//    after release with input held, the change takes the full 6 edges.
//  6 [SENSOR_STICKY_EN] rise[2] -> chg_flag[2]=1 held; chg_clr[2] clears it;
//    clr coinciding with fall[2] leaves chg_flag[2]=1.

Source files
------------

// File: rtl/sensor_debounce.sv
// Two-flop synchroniser plus per-channel debounce counter with 1-cycle rise/fall pulses.
// Optional sticky change flags (chg_flag/chg_clr) are built when SENSOR_STICKY_EN is defined.
module sensor_debounce #(
    parameter int N_CH            = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] sensor_raw,
    output logic [N_CH-1:0] sensor_out,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall
`ifdef SENSOR_STICKY_EN
    ,
    output logic [N_CH-1:0] chg_flag,
    input  logic [N_CH-1:0] chg_clr
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_CH-1:0]  s1_q, s2_q;
    logic [N_CH-1:0]  out_q, out_d;
    logic [N_CH-1:0]  rise_q, rise_d;
    logic [N_CH-1:0]  fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q [N_CH];
    logic [CNT_W-1:0] cnt_d [N_CH];

    // A mismatch must persist DEBOUNCE_CYCLES edges; any return to the current level restarts from zero.
    always_comb begin
        out_d  = out_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i] = cnt_q[i];
            if (s2_q[i] == out_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                out_d[i]  = s2_q[i];
                rise_d[i] = s2_q[i];
                fall_d[i] = ~s2_q[i];
                cnt_d[i]  = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q   <= '0;
            s2_q   <= '0;
            out_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            s1_q   <= sensor_raw;
            s2_q   <= s1_q;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign sensor_out = out_q;
    assign rise       = rise_q;
    assign fall       = fall_q;

`ifdef SENSOR_STICKY_EN
    logic [N_CH-1:0] flag_q, flag_d;

    // Set dominates clear so an event landing on a clear cycle is still recorded.
    always_comb begin
        flag_d = (flag_q & ~chg_clr) | rise_q | fall_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flag_q <= '0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign chg_flag = flag_q;
`endif

endmodule

// File: tb/tb_sensor_debounce.sv
// Bench for sensor_debounce with DEBOUNCE_CYCLES=4: fixed vector table, corner sequences,
// and randomized input compared against a sample-window reference model.
module tb_sensor_debounce;

    localparam int N = 4;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] raw;
    logic [N-1:0] sout, rise, fall;
`ifdef SENSOR_STICKY_EN
    logic [N-1:0] flag;
    logic [N-1:0] clr;
`endif

    always #5 clk = ~clk;

    sensor_debounce #(.N_CH(N), .DEBOUNCE_CYCLES(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .sensor_raw(raw),
        .sensor_out(sout),
        .rise      (rise),
        .fall      (fall)
`ifdef SENSOR_STICKY_EN
        ,
        .chg_flag  (flag),
        .chg_clr   (clr)
`endif
    );

    int checks = 0;
    int errors = 0;

    // Reference model: a level is accepted once the last D synchronised samples all differ from it.
    logic [N-1:0] m_s1, m_s2, m_out, m_rise, m_fall, m_flag;
    bit           hist [N][$];

    typedef struct {
        logic [N-1:0] raw;
        int           hold;
        logic [N-1:0] e_out;
        logic [N-1:0] e_racc;
        logic [N-1:0] e_facc;
    } vec_t;
    vec_t tbl [13];

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_s1 = '0; m_s2 = '0; m_out = '0; m_rise = '0; m_fall = '0; m_flag = '0;
        for (int i = 0; i < N; i++) hist[i].delete();
    endtask

    task automatic model_edge();
        logic [N-1:0] nr, nf;
        bit           all_diff;
        nr = '0;
        nf = '0;
`ifdef SENSOR_STICKY_EN
        m_flag = (m_flag & ~clr) | m_rise | m_fall;
`endif
        for (int i = 0; i < N; i++) begin
            hist[i].push_back(m_s2[i]);
            if (hist[i].size() > D) void'(hist[i].pop_front());
            all_diff = (hist[i].size() == D);
            foreach (hist[i][j]) if (hist[i][j] == m_out[i]) all_diff = 1'b0;
            if (all_diff) begin
                m_out[i] = ~m_out[i];
                nr[i] = m_out[i];
                nf[i] = ~m_out[i];
                hist[i].delete();
            end
        end
        m_rise = nr;
        m_fall = nf;
        m_s2 = m_s1;
        m_s1 = raw;
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) model_reset();
        else     model_edge();
        #1;
        chk("model_out", sout, m_out);
        chk("model_rise", rise, m_rise);
        chk("model_fall", fall, m_fall);
`ifdef SENSOR_STICKY_EN
        chk("model_flag", flag, m_flag);
`endif
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        logic [N-1:0] racc, facc;

        tbl[0]  = '{4'h1, 5, 4'h0, 4'h0, 4'h0};
        tbl[1]  = '{4'h1, 1, 4'h1, 4'h1, 4'h0};
        tbl[2]  = '{4'h1, 3, 4'h1, 4'h0, 4'h0};
        tbl[3]  = '{4'h3, 3, 4'h1, 4'h0, 4'h0};
        tbl[4]  = '{4'h1, 8, 4'h1, 4'h0, 4'h0};
        tbl[5]  = '{4'h3, 5, 4'h1, 4'h0, 4'h0};
        tbl[6]  = '{4'h3, 1, 4'h3, 4'h2, 4'h0};
        tbl[7]  = '{4'h3, 2, 4'h3, 4'h0, 4'h0};
        tbl[8]  = '{4'h0, 6, 4'h0, 4'h0, 4'h3};
        tbl[9]  = '{4'hA, 6, 4'hA, 4'hA, 4'h0};
        tbl[10] = '{4'h5, 5, 4'hA, 4'h0, 4'h0};
        tbl[11] = '{4'h5, 1, 4'h5, 4'h5, 4'hA};
        tbl[12] = '{4'h5, 2, 4'h5, 4'h0, 4'h0};

        rst = 1'b1;
        raw = 4'hF;
`ifdef SENSOR_STICKY_EN
        clr = '0;
`endif
        model_reset();
        steps(3);
        chk("rst_out", sout, 4'h0);
        chk("rst_rise", rise, 4'h0);
        chk("rst_fall", fall, 4'h0);

        // Input held high through reset release.
        rst = 1'b0;
        steps(5);
        chk("rel_out_e5", sout, 4'h0);
        step();
        chk("rel_out_e6", sout, 4'hF);
        chk("rel_rise_e6", rise, 4'hF);
        step();
        chk("rel_rise_e7", rise, 4'h0);
        chk("rel_out_e7", sout, 4'hF);

        raw = 4'h0;
        steps(6);
        chk("drop_out", sout, 4'h0);
        chk("drop_fall", fall, 4'hF);
        steps(3);

        for (int k = 0; k < 13; k++) begin
            raw = tbl[k].raw;
            racc = '0;
            facc = '0;
            for (int c = 0; c < tbl[k].hold; c++) begin
                step();
                racc |= rise;
                facc |= fall;
            end
            chk($sformatf("tbl%0d_out", k), sout, tbl[k].e_out);
            chk($sformatf("tbl%0d_rise", k), racc, tbl[k].e_racc);
            chk($sformatf("tbl%0d_fall", k), facc, tbl[k].e_facc);
        end

        // Reset asserted two edges into a pending change, between clock edges.
        raw = 4'hA;
        steps(2);
        rst = 1'b1;
        model_reset();
        #1;
        chk("async_rst_out", sout, 4'h0);
        chk("async_rst_rise", rise, 4'h0);
        chk("async_rst_fall", fall, 4'h0);
        steps(2);
        rst = 1'b0;
        steps(5);
        chk("mid_rst_out_e5", sout, 4'h0);
        step();
        chk("mid_rst_out_e6", sout, 4'hA);
        chk("mid_rst_rise_e6", rise, 4'hA);
        steps(2);

`ifdef SENSOR_STICKY_EN
        clr = 4'hF;
        step();
        chk("flag_clr_all", flag, 4'h0);
        clr = 4'h0;
        raw = 4'hE;
        steps(6);
        chk("stk_rise2", rise, 4'h4);
        step();
        chk("stk_flag_set", flag, 4'h4);
        steps(3);
        chk("stk_flag_hold", flag, 4'h4);
        clr = 4'h4;
        step();
        chk("stk_flag_cleared", flag, 4'h0);
        clr = 4'h0;
        raw = 4'hA;
        steps(6);
        chk("stk_fall2", fall, 4'h4);
        clr = 4'h4;
        step();
        chk("stk_set_wins", flag, 4'h4);
        clr = 4'h0;
        steps(2);
`endif

        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < N; b++)
                if ($urandom_range(0, 9) == 0) raw[b] = ~raw[b];
`ifdef SENSOR_STICKY_EN
            clr = ($urandom_range(0, 3) == 0) ? N'($urandom) : '0;
`endif
            if ($urandom_range(0, 499) == 0) begin
                rst = 1'b1;
                model_reset();
                #1;
                chk("rand_async_rst", sout, 4'h0);
                steps(2);
                rst = 1'b0;
            end
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
